// File: rtl/gun_sprite_render.sv
// Gun sprite overlay stage: window test and ROM addressing, then colour-keyed compositing
// of the returned sprite pixel over the background, three cycles from input to output.
module gun_sprite_render #(
    parameter int unsigned SPR_W   = 40,
    parameter int unsigned SPR_H   = 40,
    parameter int unsigned ADDR_W  = 11,
    parameter int unsigned X_W     = 10,
    parameter int unsigned Y_W     = 10,
    parameter logic [15:0] KEY_RGB = 16'hF81F
) (
    input  logic              clka,
    input  logic              rsta_n,
    input  logic              frame_start,
    input  logic [X_W-1:0]    pos_x,
    input  logic [Y_W-1:0]    pos_y,
    input  logic              show,
    input  logic              pix_valid,
    input  logic [X_W-1:0]    pix_x,
    input  logic [Y_W-1:0]    pix_y,
    input  logic [15:0]       bg_rgb,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [15:0]       rom_data,
    output logic              out_valid,
    output logic [15:0]       out_rgb,
    output logic              hit
);

    logic [X_W-1:0]    px;
    logic [Y_W-1:0]    py;
    logic              en;

    logic [X_W:0]      x_end;
    logic [Y_W:0]      y_end;
    logic [X_W-1:0]    col;
    logic [Y_W-1:0]    row;
    logic [ADDR_W-1:0] lin;
    logic              in_win;

    logic              v1, w1, v2, w2;
    logic [15:0]       bg1, bg2;
    logic              opaque;

    always_ff @(posedge clka) begin
        if (!rsta_n) begin
            px <= '0;
            py <= '0;
            en <= 1'b0;
        end else if (frame_start) begin
            px <= pos_x;
            py <= pos_y;
            en <= show;
        end
    end

    // Window ends are one bit wider so a sprite hanging off the right/bottom never wraps.
    always_comb begin
        x_end  = {1'b0, px} + (X_W + 1)'(SPR_W);
        y_end  = {1'b0, py} + (Y_W + 1)'(SPR_H);
        in_win = en & pix_valid
               & (pix_x >= px) & ({1'b0, pix_x} < x_end)
               & (pix_y >= py) & ({1'b0, pix_y} < y_end);
    end

    // row*SPR_W as a constant shift-and-add sum (row<<5 + row<<3 for a 40-wide sprite).
    always_comb begin
        col = pix_x - px;
        row = pix_y - py;
        lin = '0;
        for (int i = 0; i < 32; i++) begin
            if (SPR_W[i]) begin
                lin = lin + (ADDR_W'(row) << i);
            end
        end
        lin = lin + ADDR_W'(col);
    end

    always_ff @(posedge clka) begin
        if (!rsta_n) begin
            rom_addr <= '0;
            v1       <= 1'b0;
            w1       <= 1'b0;
            bg1      <= '0;
            v2       <= 1'b0;
            w2       <= 1'b0;
            bg2      <= '0;
        end else begin
            rom_addr <= in_win ? lin : '0;
            v1       <= pix_valid;
            w1       <= in_win;
            bg1      <= bg_rgb;
            v2       <= v1;
            w2       <= w1;
            bg2      <= bg1;
        end
    end

    assign opaque = w2 & (rom_data != KEY_RGB);

    always_ff @(posedge clka) begin
        if (!rsta_n) begin
            out_valid <= 1'b0;
            out_rgb   <= '0;
            hit       <= 1'b0;
        end else begin
            out_valid <= v2;
            out_rgb   <= v2 ? (opaque ? rom_data : bg2) : 16'h0000;
            hit       <= v2 & opaque;
        end
    end

endmodule

// File: tb/tb_gun_sprite_render.sv
// Directed bench for gun_sprite_render: a reference model pushes expected pixels into a
// scoreboard queue, and every cycle the outputs and ROM address are compared against it.
module tb_gun_sprite_render;

    logic        clka = 1'b0;
    logic        rsta_n;
    logic        frame_start;
    logic [9:0]  pos_x, pos_y, pix_x, pix_y;
    logic        show, pix_valid;
    logic [15:0] bg_rgb;
    logic [10:0] rom_addr;
    logic [15:0] rom_data = 16'h0000;
    logic        out_valid, hit;
    logic [15:0] out_rgb;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Model state
    int          mpx = 0, mpy = 0;
    bit          men = 1'b0;
    int          exp_addr = 0;
    logic [15:0] rom83 = 16'h07E0;

    typedef struct {
        int          due;
        logic [15:0] rgb;
        logic        hit;
    } exp_t;
    exp_t sb[$];

    gun_sprite_render dut (
        .clka        (clka),
        .rsta_n      (rsta_n),
        .frame_start (frame_start),
        .pos_x       (pos_x),
        .pos_y       (pos_y),
        .show        (show),
        .pix_valid   (pix_valid),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .bg_rgb      (bg_rgb),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .out_valid   (out_valid),
        .out_rgb     (out_rgb),
        .hit         (hit)
    );

    always #5 clka = ~clka;

    function automatic logic [15:0] rom_fn(int a);
        return (a == 83) ? rom83 : (16'h0800 | 16'(a));
    endfunction

    // One-cycle synchronous-read ROM with unregistered output
    always @(posedge clka) rom_data <= rom_fn(int'(rom_addr));

    task automatic chk(string tag, logic [31:0] got, logic [31:0] want);
        checks++;
        assert (got === want) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    task automatic tick();
        int   col, row, a;
        bit   win;
        exp_t e;
        col = int'(pix_x) - mpx;
        row = int'(pix_y) - mpy;
        win = men && pix_valid && col >= 0 && col < 40 && row >= 0 && row < 40;
        a   = win ? row * 40 + col : 0;
        @(posedge clka);
        cyc++;
        if (!rsta_n) begin
            sb.delete();
            mpx = 0; mpy = 0; men = 1'b0;
            exp_addr = 0;
        end else begin
            exp_addr = a;
            if (pix_valid) begin
                e.due = cyc + 2;
                e.hit = win && (rom_fn(a) != 16'hF81F);
                e.rgb = e.hit ? rom_fn(a) : bg_rgb;
                sb.push_back(e);
            end
            if (frame_start) begin
                mpx = int'(pos_x); mpy = int'(pos_y); men = show;
            end
        end
        #1;
        chk("rom_addr", 32'(rom_addr), 32'(exp_addr));
        if (out_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_out_valid", 32'(out_valid), 32'd0);
            end else begin
                e = sb.pop_front();
                chk("latency", 32'(cyc), 32'(e.due));
                chk("out_rgb", 32'(out_rgb), 32'(e.rgb));
                chk("hit", 32'(hit), 32'(e.hit));
            end
        end else begin
            chk("idle_rgb", 32'(out_rgb), 32'd0);
            chk("idle_hit", 32'(hit), 32'd0);
            if (sb.size() != 0 && sb[0].due <= cyc)
                chk("missing_out_valid", 32'(out_valid), 32'd1);
        end
        frame_start = 1'b0;
        pix_valid   = 1'b0;
    endtask

    task automatic pixel(int x, int y, logic [15:0] bg);
        pix_valid = 1'b1;
        pix_x     = 10'(x);
        pix_y     = 10'(y);
        bg_rgb    = bg;
    endtask

    task automatic frame(int x, int y, bit s);
        frame_start = 1'b1;
        pos_x       = 10'(x);
        pos_y       = 10'(y);
        show        = s;
    endtask

    task automatic drain();
        for (int i = 0; i < 6; i++) tick();
        chk("drained", 32'(sb.size()), 32'd0);
        sb.delete();
    endtask

    initial begin
        rsta_n = 1'b0;
        frame_start = 1'b0; pos_x = '0; pos_y = '0; show = 1'b0;
        pix_valid = 1'b0; pix_x = '0; pix_y = '0; bg_rgb = '0;

        tick(); tick();
        rsta_n = 1'b1;
        for (int i = 0; i < 3; i++) tick();

        // Opaque hit inside the window
        frame(100, 50, 1'b1); tick();
        rom83 = 16'h07E0;
        pixel(103, 52, 16'h001F); tick();
        drain();

        // Colour-key transparency
        rom83 = 16'hF81F;
        pixel(103, 52, 16'h001F); tick();
        drain();
        rom83 = 16'h07E0;

        // Horizontal window edges, with a bubble in the stream
        pixel(99, 50, 16'h1111);  tick();
        pixel(100, 50, 16'h2222); tick();
        tick();
        pixel(139, 50, 16'h3333); tick();
        pixel(140, 50, 16'h4444); tick();
        pixel(120, 89, 16'h5555); tick();
        pixel(120, 90, 16'h6666); tick();
        drain();

        // Sprite clipped by the right/bottom edge must not wrap
        frame(1010, 1000, 1'b1); tick();
        pixel(1023, 1020, 16'h0101); tick();
        pixel(5, 5, 16'h0202);       tick();
        pixel(1009, 1000, 16'h0303); tick();
        drain();

        // Hiding the sprite on the same cycle as an in-window pixel
        frame(100, 50, 1'b1); tick();
        pixel(110, 60, 16'h0A0A); frame(100, 50, 1'b0); tick();
        pixel(111, 60, 16'h0B0B); tick();
        pixel(112, 61, 16'h0C0C); tick();
        drain();

        // Reset with two pixels in flight discards them
        frame(100, 50, 1'b1); tick();
        pixel(101, 51, 16'h0D0D); tick();
        pixel(102, 52, 16'h0E0E); tick();
        rsta_n = 1'b0; tick();
        rsta_n = 1'b1; tick();
        tick(); tick();
        chk("flushed_out_valid", 32'(out_valid), 32'd0);

        // Position was cleared by reset; re-enable and check first post-reset pixel
        pixel(101, 51, 16'h0F0F); tick();
        frame(100, 50, 1'b1); tick();
        pixel(101, 51, 16'h1F1F); tick();
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gun_sprite_render.md
# gun_sprite_render

Pixel-pipeline stage that sits directly upstream of the 40x40 gun sprite ROM (1600 x 16-bit RGB565, single-port, one-cycle read, unregistered output). For each pixel coordinate streamed from the display timing chain, it decides whether the pixel falls inside the gun sprite window. It drives the ROM address and overlays the returned sprite colour on the incoming background colour, with colour-key transparency. It emits the composited pixel and a per-pixel opaque-hit flag for collision logic.

## Interface
Parameters:
- SPR_W, 40, sprite width in pixels
- SPR_H, 40, sprite height in pixels
- ADDR_W, 11, ROM address width
- X_W, 10, pixel x coordinate width
- Y_W, 10, pixel y coordinate width
- KEY_RGB, 16'hF81F, transparent colour key (RGB565 magenta)

Ports:
- clka  in  1  system clock; all logic on the rising edge
- rsta_n  in  1  synchronous, active-low reset
- frame_start  in  1  one-cycle pulse at the start of each frame; latches the sprite position
- pos_x  in  X_W  sprite top-left x, sampled only on frame_start
- pos_y  in  Y_W  sprite top-left y, sampled only on frame_start
- show  in  1  sprite enable, sampled only on frame_start
- pix_valid  in  1  pix_x, pix_y and bg_rgb are valid this cycle
- pix_x  in  X_W  current pixel x
- pix_y  in  Y_W  current pixel y
- bg_rgb  in  16  background colour for this pixel
- rom_addr  out  ADDR_W  to ROM addra (registered)
- rom_data  in  16  from ROM doa; valid one cycle after rom_addr
- out_valid  out  1  out_rgb and hit are valid
- out_rgb  out  16  composited pixel
- hit  out  1  an opaque sprite pixel was drawn at this pixel

## Operation
- Position registers: px, py and en load pos_x, pos_y and show when frame_start=1. Reset values are 0, 0 and 0. A pixel presented in the same cycle as frame_start uses the old values.
- Window test (stage 1):
  - in_win = en & pix_valid & (pix_x ≥ px) & (pix_x < px+SPR_W) & (pix_y ≥ py) & (pix_y < py+SPR_H).
  - px+SPR_W and py+SPR_H are computed one bit wider than X_W and Y_W, so a sprite partly off the right or bottom edge does not wrap.
- Address (stage 1): col = pix_x−px and row = pix_y−py. When in_win=1, rom_addr = row*SPR_W + col, implemented with shifts and adds (row<<5 + row<<3 for 40). When in_win=0, rom_addr = 0. The range is 0..1599, and no address ≥ SPR_W*SPR_H is ever issued.
- Stage 1 registers: rom_addr, v1=pix_valid, w1=in_win, bg1=bg_rgb.
- Stage 2 registers: v2=v1, w2=w1, bg2=bg1. The ROM samples rom_addr on this same edge.
- Stage 3 (output) registers:
  - opaque = w2 & (rom_data ≠ KEY_RGB).
  - out_valid = v2.
  - out_rgb = opaque ? rom_data : bg2 when v2=1, else 0.
  - hit = v2 & opaque.
- No backpressure. One pixel is accepted per cycle, and pix_valid gaps propagate as bubbles.

## Timing
- Latency: a pixel sampled at edge k appears on out_* after edge k+2, i.e. 3 cycles from input to visible output. Throughput is 1 pixel per clock.
- rom_addr is valid after edge k. rom_data is valid after edge k+1.
- Reset (rsta_n=0 at an edge) clears px, py, en, rom_addr, v1, w1, bg1, v2, w2, bg2, out_valid, out_rgb and hit to 0.
  - Reset mid-stream discards every pixel in flight.
  - The first valid output after release appears 3 cycles after the first pix_valid.
- frame_start takes effect from the next cycle. Pixels already in the pipeline complete with the position they sampled.
- rom_data is ignored when w2=0.

## Test plan
- Reset then idle: rsta_n low for 2 cycles, then pix_valid=0 → rom_addr=0, out_valid=0, out_rgb=0, hit=0 on every cycle.
- Inside window:
  - Stimulus: frame_start with pos=(100,50), show=1; then pixel (103,52) with bg=16'h001F; ROM model returns 16'h07E0.
  - Required: rom_addr=83 one cycle after sampling; out_rgb=16'h07E0, hit=1, out_valid=1 three cycles after input.
- Transparency: same setup, ROM returns 16'hF81F → out_rgb=16'h001F, hit=0.
- Window edges: pos=(100,50); pixels x=99, 100, 139, 140 at y=50 → hit only for x=100 and x=139, with rom_addr 0 and 39.
- Edge clip: pos=(1010,1000), X_W=Y_W=10; pixel (1023,1020) → in window, rom_addr=20*40+13=813. Pixel (5,5) → not in window (no wrap).
- Position update and reset:
  - frame_start with show=0 in the same cycle as an in-window pixel → that pixel is still drawn, and the following in-window pixels give hit=0.
  - Assert rsta_n=0 with 2 pixels in flight → out_valid stays 0 for those pixels.
